// File: rtl/acc_40b.sv
// Burst accumulator: sums a stream of W-bit beats up to in_last and presents sum, sticky carry and beat count.
// Optional macro ACC40_SAT_EN clamps the sum to all-ones once a carry has occurred in the burst.
module acc_40b #(
  parameter int W     = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_next;
  logic             ovf;
  logic             ovf_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [W:0]       sum_ext;

  assign sum_ext = {1'b0, acc} + {1'b0, in_data};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      ovf   <= ovf_next;
      cnt   <= cnt_next;
    end
  end

  // in_ready depends only on the registered state, so out_ready never reaches it combinationally.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    ovf_next   = ovf;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next   = in_data;
          ovf_next   = 1'b0;
          cnt_next   = CNT_ONE;
          state_next = in_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_next = sum_ext[W-1:0];
          ovf_next = ovf | sum_ext[W];
`ifdef ACC40_SAT_EN
          if (ovf_next) acc_next = '1;
`endif
          if (cnt != CNT_MAX) cnt_next = cnt + CNT_ONE;
          if (in_last) state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_sum = acc;
  assign out_ovf = ovf;
  assign out_cnt = cnt;

endmodule

// File: tb/tb_acc_40b.sv
// Self-checking bench for acc_40b: directed scenarios plus random bursts against a burst-level arithmetic model.
// Define ACC40_SAT_EN for both bench and RTL to check the saturating build.
module tb_acc_40b;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_sum;
  logic        out_ovf;
  logic [7:0]  out_cnt;

  int checks = 0;
  int errors = 0;

  logic [39:0] burst[$];

  acc_40b #(.W(40), .CNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_ovf  (out_ovf),
    .out_cnt  (out_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one beat and holds it until the block has taken it; returns just after the accepting edge.
  task automatic applyStimulus(input logic [39:0] d, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) checkOutput("ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Burst-level view: the true sum of all beats decides carry, wrapped/saturated sum and clamped count.
  task automatic model(output logic [39:0] e_sum, output logic e_ovf, output logic [7:0] e_cnt);
    logic [63:0] total;
    total = 64'd0;
    foreach (burst[i]) total += {24'd0, burst[i]};
    e_ovf = (total >= 64'h100_0000_0000);
`ifdef ACC40_SAT_EN
    e_sum = e_ovf ? 40'hFF_FFFF_FFFF : total[39:0];
`else
    e_sum = total[39:0];
`endif
    e_cnt = (burst.size() > 255) ? 8'd255 : 8'(burst.size());
  endtask

  // Called right after the last beat's accepting edge; checks 1-cycle latency, hold while stalled, and release.
  task automatic checkResult(input string tag, input logic [39:0] e_sum, input logic e_ovf,
                             input logic [7:0] e_cnt, input int hold);
    @(negedge clk);
    checkOutput({tag, "_valid"}, out_valid, 1);
    checkOutput({tag, "_sum"}, out_sum, e_sum);
    checkOutput({tag, "_ovf"}, out_ovf, e_ovf);
    checkOutput({tag, "_cnt"}, out_cnt, e_cnt);
    checkOutput({tag, "_ready_low"}, in_ready, 0);
    out_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, out_valid, 1);
      checkOutput({tag, "_hold_sum"}, out_sum, e_sum);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput({tag, "_released"}, out_valid, 0);
  endtask

  task automatic runBurst(input string tag, input int hold, input bit gaps);
    logic [39:0] e_sum;
    logic        e_ovf;
    logic [7:0]  e_cnt;
    model(e_sum, e_ovf, e_cnt);
    for (int i = 0; i < burst.size(); i++) begin
      applyStimulus(burst[i], i == burst.size() - 1);
      if (gaps && i != burst.size() - 1 && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
    end
    checkResult(tag, e_sum, e_ovf, e_cnt, hold);
  endtask

  function automatic logic [39:0] randData();
    logic [31:0] lo;
    logic [31:0] hi;
    lo = $urandom;
    hi = $urandom;
    case ($urandom_range(0, 3))
      0:       return 40'($urandom_range(0, 1000));
      1:       return {8'hFF, lo};
      2:       return {hi[7:0], lo};
      default: return 40'hFF_FFFF_FFFF;
    endcase
  endfunction

  initial begin
    logic [39:0] pend;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sum", out_sum, 0);
    checkOutput("rst_ovf", out_ovf, 0);
    checkOutput("rst_cnt", out_cnt, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1);

    out_ready = 1'b1;
    burst = '{40'd5, 40'd7, 40'd9};
    runBurst("b579", 0, 1'b0);
    checkOutput("b579_model_sum", 64'd21, {24'd0, dut.out_sum});

    burst = '{40'hFF_FFFF_FFFF, 40'h2};
    runBurst("wrap", 0, 1'b0);

    burst = '{40'h12_3456_789A};
    runBurst("single", 0, 1'b0);

    burst = '{randData(), randData(), randData()};
    runBurst("stall", 0, 1'b0);
    // Stall in DONE with a waiting beat, then confirm it lands only after the handshake.
    burst = '{40'd11, 40'd22};
    applyStimulus(burst[0], 1'b0);
    applyStimulus(burst[1], 1'b1);
    @(negedge clk);
    out_ready = 1'b0;
    pend      = 40'hAB_CDEF_0123;
    in_valid  = 1'b1;
    in_data   = pend;
    in_last   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_valid", out_valid, 1);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_sum", out_sum, 33);
      checkOutput("stall_cnt", out_cnt, 2);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("stall_idle_valid", out_valid, 0);
    checkOutput("stall_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    burst = '{pend};
    checkResult("pending", pend, 1'b0, 8'd1, 0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(40'd1, i == 3);
      if (i != 3) begin
        @(posedge clk);
        #1;
      end
    end
    checkResult("toggle", 40'd4, 1'b0, 8'd4, 0);

    applyStimulus(40'd50, 1'b0);
    applyStimulus(40'd60, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_ready", in_ready, 1);
    checkOutput("midrst_cnt", out_cnt, 0);
    burst = '{40'd3};
    runBurst("after_rst", 0, 1'b0);

    burst.delete();
    for (int i = 0; i < 260; i++) burst.push_back(40'd1);
    runBurst("cnt_sat", 0, 1'b0);

    for (int b = 0; b < 20; b++) begin
      burst.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) burst.push_back(randData());
      runBurst($sformatf("rand%0d", b), $urandom_range(0, 3), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_40b.md
ACC_40B -- requirements
Module: acc_40b

Interface
REQ-001 Parameter W, default 40, datapath width; the team instantiates only W=40, matching the 40-bit ripple-carry adder.
REQ-002 Parameter CNT_W, default 8, beat-counter width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in_valid  input  1  an operand beat is present.
REQ-006 in_ready  output  1  the block accepts a beat this cycle.
REQ-007 in_data  input  W  operand to be accumulated.
REQ-008 in_last  input  1  marks the final beat of a burst.
REQ-009 out_valid  output  1  burst result available.
REQ-010 out_ready  input  1  downstream consumes the result.
REQ-011 out_sum  output  W  accumulated sum of the burst.
REQ-012 out_ovf  output  1  sticky carry-out over the burst.
REQ-013 out_cnt  output  CNT_W  beats accepted in the burst.

Function
REQ-014 A beat is accepted only when in_valid and in_ready are both 1 on a rising clk.
REQ-015 The FSM shall have three states: IDLE, ACCUM and DONE.
REQ-016 in_ready shall be 1 in IDLE and ACCUM and 0 in DONE.
REQ-017 out_valid shall be 1 only in DONE.
REQ-018 The first beat accepted in IDLE shall set acc = in_data, ovf = 0 and cnt = 1.
REQ-019 From IDLE, the next state shall be DONE if in_last is 1, otherwise ACCUM.
REQ-020 Each beat accepted in ACCUM shall compute {c, s} = acc + in_data as W-bit unsigned with carry-in 0, then set acc = s, ovf = ovf | c, and cnt = cnt + 1.
REQ-021 cnt shall saturate at 2^CNT_W-1 and shall not wrap.
REQ-022 From ACCUM, the next state shall be DONE if the accepted beat has in_last = 1, otherwise the state stays ACCUM.
REQ-023 A cycle with no accepted beat shall leave acc, ovf, cnt and the state unchanged.
REQ-024 out_sum, out_ovf and out_cnt shall be driven directly from registers.
REQ-025 The result outputs shall be valid in the cycle after the in_last beat is accepted; latency is 1 clk.
REQ-026 In DONE, the result outputs shall be held stable until out_ready is 1.
REQ-027 When DONE and out_ready are both 1, the next state shall be IDLE; acc, ovf and cnt may retain their values.
REQ-028 In DONE, in_valid shall be ignored and no beat shall be lost: in_ready is 0, so upstream holds the beat.
REQ-029 There shall be no combinational path from out_ready to in_ready; a new burst can start no earlier than the cycle after the handshake.
REQ-030 Wrap-around: with the macro in REQ-035 undefined, an overflowing sum shall keep the low W bits, and ovf shall flag the overflow.

Reset
REQ-031 While reset is 1, the state shall be IDLE.
REQ-032 While reset is 1, acc = 0, ovf = 0 and cnt = 0.
REQ-033 While reset is 1, out_valid shall be 0 and in_ready shall be 1 from the cycle after reset is sampled.
REQ-034 A reset asserted mid-burst or in DONE shall discard the partial or pending result with no output handshake.

Configuration
REQ-035 Macro ACC40_SAT_EN, when defined, shall enable saturation: once ovf = 1, acc shall be forced to all-ones (2^W-1) and stay there for the rest of the burst.
REQ-036 Saturation under REQ-035 shall include the beat that produced the carry.
REQ-037 With ACC40_SAT_EN undefined, accumulation shall wrap as in REQ-030.
REQ-038 With ACC40_SAT_EN undefined, no saturation logic shall be present.

Verification
REQ-039 Beats 5, 7, 9 (last) with out_ready = 1 -> out_sum = 21, out_ovf = 0, out_cnt = 3, and out_valid high for exactly 1 cycle.
REQ-040 Beats 0xFF_FFFF_FFFF and 0x2 (last) -> out_ovf = 1 and out_cnt = 2; out_sum = 0x1 without the macro and 0xFF_FFFF_FFFF with ACC40_SAT_EN.
REQ-041 A single beat 0x12_3456_789A with in_last = 1 -> DONE next cycle, out_sum = 0x12_3456_789A, out_cnt = 1.
REQ-042 out_ready held 0 for 10 cycles in DONE while in_valid = 1 -> outputs stable, in_ready = 0; the pending beat is accepted in the cycle after out_ready = 1.
REQ-043 in_valid toggling 1,0,1,0 over 4 beats of value 1 -> out_sum = 4, out_cnt = 4.
REQ-044 reset pulsed after 2 of 4 beats -> out_valid stays 0; the next burst of 3 (last) -> out_sum = 3, out_cnt = 1.
